// File: rtl/data_mem_stage_if.sv
// data_mem_stage_if: execute-to-memory request bus and writeback result bus
interface data_mem_stage_if;
  logic        valid_in;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memread;
  logic        memwrite;
  logic        size;
  logic        sign_ext;
  logic [4:0]  rd_in;
  logic        valid_out;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        misalign;
  modport master (
    output valid_in, addr, wdata, memread, memwrite, size, sign_ext, rd_in,
    input  valid_out, result, rd_out, misalign
  );
  modport slave (
    input  valid_in, addr, wdata, memread, memwrite, size, sign_ext, rd_in,
    output valid_out, result, rd_out, misalign
  );
endinterface

// File: rtl/data_mem_stage.sv
// data_mem_stage: single-cycle data memory stage with word/byte loads and stores
module data_mem_stage #(
  parameter int DEPTH = 256
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   r_mem [DEPTH];
  logic          r_valid;
  logic [31:0]   r_result;
  logic [4:0]    r_rd;
  logic          r_mis;
  logic [AW-1:0] w_idx;
  logic [4:0]    w_sh;
  logic [31:0]   w_word;
  logic [31:0]   w_lane_sh;
  logic [31:0]   w_ext;
  logic [31:0]   w_mask;
  logic [31:0]   w_byte;
  logic [31:0]   w_new;
  logic [31:0]   w_res;
  logic          w_acc;
  logic          w_mis;
  logic          w_we;
  logic          w_unused;
  // upper address bits beyond the memory span wrap around
  assign w_idx     = bus.addr[AW+1:2];
  assign w_sh      = {bus.addr[1:0], 3'b000};
  assign w_word    = r_mem[w_idx];
  assign w_lane_sh = w_word >> w_sh;
  assign w_ext     = {{24{bus.sign_ext & w_lane_sh[7]}}, w_lane_sh[7:0]};
  assign w_mask    = 32'h0000_00FF << w_sh;
  assign w_byte    = {24'b0, bus.wdata[7:0]} << w_sh;
  assign w_new     = bus.size ? ((w_word & ~w_mask) | w_byte) : bus.wdata;
  assign w_acc     = bus.valid_in & (bus.memread | bus.memwrite);
  assign w_mis     = w_acc & ~bus.size & (|bus.addr[1:0]);
  assign w_we      = bus.valid_in & bus.memwrite & ~w_mis;
  // load data is taken from the pre-write word, giving read-before-write
  assign w_res     = (!bus.valid_in || w_mis) ? '0 :
                     bus.memread ? (bus.size ? w_ext : w_word) : bus.addr;
  assign w_unused  = ^{bus.addr[31:AW+2], w_lane_sh[31:8]};
  // memory array, cleared on reset, updated by accepted stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[w_idx] <= w_new;
    end
  end
  // registered writeback outputs, one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
      r_mis    <= 1'b0;
    end else begin
      r_valid  <= bus.valid_in;
      r_result <= w_res;
      r_rd     <= bus.rd_in;
      r_mis    <= w_mis;
    end
  end
  assign bus.valid_out = r_valid;
  assign bus.result    = r_result;
  assign bus.rd_out    = r_rd;
  assign bus.misalign  = r_mis;
endmodule
